// File: rtl/fonk_sweep_checker.sv
// fonk_sweep_checker: sweeps all 32 input vectors of a 5-input function and scores F against a truth table
module fonk_sweep_checker #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] expected,
  input  logic        f_in,
  output logic [4:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [5:0]  pass_count,
  output logic [5:0]  fail_count,
  output logic        all_pass,
  output logic [4:0]  first_fail_idx,
  output logic        first_fail_valid
);
  typedef enum logic [1:0] {IDLE, SETTLE_W, SAMPLE, DONE_S} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  vec_q, vec_d, ffi_q, ffi_d;
  logic [5:0]  pass_q, pass_d, fail_q, fail_d;
  logic        ffv_q, ffv_d;
  logic        go, smp, hit;
  // state register
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // next-state: hold each vector SETTLE cycles, sample once, stop after vector 31
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE_S: state_d = start ? SETTLE_W : state_q;
      SETTLE_W:     state_d = (cnt_q == 4'(SETTLE - 1)) ? SAMPLE : SETTLE_W;
      SAMPLE:       state_d = (vec_q == 5'd31) ? DONE_S : SETTLE_W;
      default:      state_d = IDLE;
    endcase
  end
  // datapath next values; start is only honoured when no sweep is running
  always_comb begin
    go     = (state_q == IDLE || state_q == DONE_S) && start;
    smp    = state_q == SAMPLE;
    hit    = f_in == expected[vec_q];
    cnt_d  = (state_q == SETTLE_W) ? cnt_q + 4'd1 : 4'd0;
    vec_d  = go ? 5'd0 : (smp && vec_q != 5'd31) ? vec_q + 5'd1 : vec_q;
    pass_d = go ? 6'd0 : (smp && hit) ? pass_q + 6'd1 : pass_q;
    fail_d = go ? 6'd0 : (smp && !hit) ? fail_q + 6'd1 : fail_q;
    ffv_d  = go ? 1'b0 : (smp && !hit) ? 1'b1 : ffv_q;
    ffi_d  = go ? 5'd0 : (smp && !hit && !ffv_q) ? vec_q : ffi_q;
  end
  // datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q  <= '0;
      vec_q  <= '0;
      pass_q <= '0;
      fail_q <= '0;
      ffv_q  <= 1'b0;
      ffi_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      vec_q  <= vec_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      ffv_q  <= ffv_d;
      ffi_q  <= ffi_d;
    end
  // outputs decoded from state and result registers
  always_comb begin
    busy             = state_q == SETTLE_W || state_q == SAMPLE;
    done             = state_q == DONE_S;
    all_pass         = done && pass_q == 6'd32;
    vec              = vec_q;
    pass_count       = pass_q;
    fail_count       = fail_q;
    first_fail_idx   = ffi_q;
    first_fail_valid = ffv_q;
  end
endmodule

// File: tb/tb_fonk_sweep_checker.sv
// tb_fonk_sweep_checker: scoreboard bench for fonk_sweep_checker at SETTLE=1 and SETTLE=3
module tb_fonk_sweep_checker;
  typedef struct {
    int pass_n;
    int fail_n;
    int ffv;
    int ffi;
    int allp;
    int cyc;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0;
  int          fmode = 0;
  logic [31:0] expected = 32'hEFFF8FFF;
  logic        f1, f3, d1 = 1'b0, d2 = 1'b0;
  logic [4:0]  vec1, vec3, ffi1, ffi3;
  logic [5:0]  pass1, pass3, fail1, fail3;
  logic        busy1, busy3, done1, done3, allp1, allp3, ffv1, ffv3;
  int          n_cmp = 0, n_bad = 0;
  exp_t        sb[$];
  wire [4:0] vec_m  = sel ? vec3  : vec1;
  wire [4:0] ffi_m  = sel ? ffi3  : ffi1;
  wire [5:0] pass_m = sel ? pass3 : pass1;
  wire [5:0] fail_m = sel ? fail3 : fail1;
  wire       busy_m = sel ? busy3 : busy1;
  wire       done_m = sel ? done3 : done1;
  wire       allp_m = sel ? allp3 : allp1;
  wire       ffv_m  = sel ? ffv3  : ffv1;
  always #5 clk = ~clk;
  always_comb f1 = (fmode == 0) ? expected[vec1] : (fmode == 1);
  always @(posedge clk) begin
    d1 <= expected[vec3];
    d2 <= d1;
  end
  always_comb f3 = (fmode == 0) ? d2 : (fmode == 1);
  fonk_sweep_checker #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start & ~sel), .expected(expected), .f_in(f1),
    .vec(vec1), .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1),
    .all_pass(allp1), .first_fail_idx(ffi1), .first_fail_valid(ffv1)
  );
  fonk_sweep_checker #(.SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .start(start & sel), .expected(expected), .f_in(f3),
    .vec(vec3), .busy(busy3), .done(done3), .pass_count(pass3), .fail_count(fail3),
    .all_pass(allp3), .first_fail_idx(ffi3), .first_fail_valid(ffv3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask
  function automatic exp_t model(input int mode);
    exp_t e;
    logic f;
    e = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 32; i++) begin
      f = (mode == 0) ? expected[i] : (mode == 1);
      if (f == expected[i]) e.pass_n++;
      else begin
        if (e.ffv == 0) e.ffi = i;
        e.ffv = 1;
        e.fail_n++;
      end
    end
    e.allp = (e.pass_n == 32);
    return e;
  endfunction
  task automatic check_idle(input string tag);
    chk({tag, "_vec"}, 32'(vec_m), 0);
    chk({tag, "_busy"}, 32'(busy_m), 0);
    chk({tag, "_done"}, 32'(done_m), 0);
    chk({tag, "_pass"}, 32'(pass_m), 0);
    chk({tag, "_fail"}, 32'(fail_m), 0);
    chk({tag, "_allp"}, 32'(allp_m), 0);
    chk({tag, "_ffi"}, 32'(ffi_m), 0);
    chk({tag, "_ffv"}, 32'(ffv_m), 0);
  endtask
  task automatic run(input bit s, input int mode, input int mid);
    exp_t e, w;
    int n;
    bit pulsed;
    e = model(mode);
    e.cyc = 32 * (s ? 4 : 2);
    sb.push_back(e);
    @(negedge clk);
    sel = s;
    fmode = mode;
    start = 1'b1;
    n = 0;
    pulsed = 0;
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (n == 1) begin
        chk("start_busy", 32'(busy_m), 1);
        chk("start_done", 32'(done_m), 0);
        chk("start_vec", 32'(vec_m), 0);
        chk("start_pass", 32'(pass_m), 0);
        chk("start_fail", 32'(fail_m), 0);
        chk("start_ffv", 32'(ffv_m), 0);
      end
      if (mid >= 0 && !pulsed && vec_m == 5'(mid)) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (done_m) break;
      if (allp_m) chk("allp_busy", 32'(allp_m), 0);
      if (n > 1000) begin
        chk("done_timeout", 32'(n), 32'(e.cyc + 1));
        break;
      end
    end
    w = sb.pop_front();
    chk("done_cyc", 32'(n - 1), 32'(w.cyc));
    chk("pass", 32'(pass_m), 32'(w.pass_n));
    chk("fail", 32'(fail_m), 32'(w.fail_n));
    chk("ffv", 32'(ffv_m), 32'(w.ffv));
    if (w.ffv != 0) chk("ffi", 32'(ffi_m), 32'(w.ffi));
    chk("allp", 32'(allp_m), 32'(w.allp));
    chk("busy_done", 32'(busy_m), 0);
    repeat (3) @(negedge clk);
    chk("hold_pass", 32'(pass_m), 32'(w.pass_n));
    chk("hold_fail", 32'(fail_m), 32'(w.fail_n));
    chk("hold_vec", 32'(vec_m), 31);
    chk("hold_done", 32'(done_m), 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("rst");
    run(0, 0, -1);
    run(0, 1, -1);
    run(0, 2, 5);
    @(negedge clk);
    sel = 1'b0;
    fmode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && vec_m != 5'd10; k++) @(negedge clk);
    chk("reach_vec10", 32'(vec_m), 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst");
    run(0, 1, -1);
    run(1, 0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
